// File: rtl/rst_seq_pkg.sv
// Shared types, defaults and constant helpers for the reset sequencer.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_WAIT = 2'd1,
    ST_GAP  = 2'd2,
    ST_RUN  = 2'd3
  } seq_state_e;

  localparam int DEF_NUM_DOM  = 4;
  localparam int DEF_HOLD_CYC = 8;
  localparam int DEF_GAP_CYC  = 4;
  localparam int DEF_TMO_CYC  = 64;

  // Ceiling log2, never below 1 so single-value fields still get a bit.
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/rst_seq_cnt.sv
// Shared cycle counter: synchronous clear, enable, terminal-count compare.
module rst_seq_cnt
  import rst_seq_pkg::*;
#(
  parameter int W = clog2(DEF_TMO_CYC)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] tc_val,
  output logic [W-1:0] cnt,
  output logic         at_tc
);

  assign at_tc = (cnt == tc_val);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: holds all domains, then releases them one at a time,
// waiting for each ready (with timeout) and spacing releases by a gap.
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int NUM_DOM  = DEF_NUM_DOM,
  parameter int HOLD_CYC = DEF_HOLD_CYC,
  parameter int GAP_CYC  = DEF_GAP_CYC,
  parameter int TMO_CYC  = DEF_TMO_CYC,
  localparam int IW      = clog2(NUM_DOM)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sw_rst_req,
  input  logic [NUM_DOM-1:0] dom_rdy,
  output logic [NUM_DOM-1:0] dom_rst,
  output logic               seq_done,
  output logic               seq_err,
  output logic [IW-1:0]      err_dom
);

  localparam int CW = clog2(max3(HOLD_CYC, GAP_CYC, TMO_CYC));
  localparam logic [NUM_DOM-1:0] DOM_ONE = NUM_DOM'(1);

  seq_state_e    state;
  logic [IW-1:0] idx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] tc_val;
  logic          at_tc;
  logic          cnt_clr;
  logic          cnt_en;
  logic          rdy_cur;
  logic          last_dom;

  assign rdy_cur  = dom_rdy[idx];
  assign last_dom = (idx == IW'(NUM_DOM - 1));

  // Each state picks its own terminal count and clears the counter on exit.
  always_comb begin
    tc_val  = '0;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (state)
      ST_HOLD: begin
        tc_val  = CW'(HOLD_CYC - 1);
        cnt_clr = sw_rst_req | at_tc;
        cnt_en  = 1'b1;
      end
      ST_WAIT: begin
        tc_val  = CW'(TMO_CYC - 1);
        cnt_clr = sw_rst_req | rdy_cur | at_tc;
        cnt_en  = 1'b1;
      end
      ST_GAP: begin
        tc_val  = CW'(GAP_CYC - 1);
        cnt_clr = sw_rst_req | at_tc;
        cnt_en  = 1'b1;
      end
      default: cnt_clr = 1'b1;
    endcase
  end

  rst_seq_cnt #(.W(CW)) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .tc_val (tc_val),
    .cnt    (cnt),
    .at_tc  (at_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_HOLD;
      idx      <= '0;
      dom_rst  <= '0;
      seq_done <= 1'b0;
      seq_err  <= 1'b0;
      err_dom  <= '0;
    end else if (sw_rst_req && state != ST_HOLD) begin
      state    <= ST_HOLD;
      idx      <= '0;
      dom_rst  <= '0;
      seq_done <= 1'b0;
      seq_err  <= 1'b0;
      err_dom  <= '0;
    end else begin
      case (state)
        ST_HOLD: begin
          if (!sw_rst_req && at_tc) begin
            state   <= ST_WAIT;
            dom_rst <= DOM_ONE;
          end
        end
        ST_WAIT: begin
          if (rdy_cur || at_tc) begin
            if (!rdy_cur) begin
              seq_err <= 1'b1;
              if (!seq_err) err_dom <= idx;
            end
            if (last_dom) begin
              state    <= ST_RUN;
              seq_done <= 1'b1;
            end else begin
              state <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (at_tc) begin
            idx     <= idx + 1'b1;
            dom_rst <= dom_rst | (DOM_ONE << (idx + 1'b1));
            state   <= ST_WAIT;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: per-cycle comparison against a release-schedule
// model computed from per-domain ready latencies.
module tb_rst_seq_ctrl;
  import rst_seq_pkg::*;

  localparam int ND    = 4;
  localparam int HOLD  = 8;
  localparam int GAP   = 4;
  localparam int TMO   = 64;
  localparam int NEVER = 1000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sw_rst_req = 1'b0;
  logic [ND-1:0] dom_rdy = '0;
  logic [ND-1:0] dom_rst;
  logic          seq_done;
  logic          seq_err;
  logic [1:0]    err_dom;

  logic          rst_n1 = 1'b0;
  logic          sw_rst_req1 = 1'b0;
  logic [0:0]    dom_rdy1 = 1'b1;
  logic [0:0]    dom_rst1;
  logic          seq_done1;
  logic          seq_err1;
  logic [0:0]    err_dom1;

  int n_chk  = 0;
  int n_pass = 0;
  int cur_k  = 0;

  int rel[ND];
  int done_e, err_e, err_i;

  always #5 clk = ~clk;

  rst_seq_ctrl #(.NUM_DOM(ND), .HOLD_CYC(HOLD), .GAP_CYC(GAP), .TMO_CYC(TMO)) u_dut (
    .clk(clk), .rst_n(rst_n), .sw_rst_req(sw_rst_req), .dom_rdy(dom_rdy),
    .dom_rst(dom_rst), .seq_done(seq_done), .seq_err(seq_err), .err_dom(err_dom)
  );

  rst_seq_ctrl #(.NUM_DOM(1), .HOLD_CYC(HOLD), .GAP_CYC(GAP), .TMO_CYC(TMO)) u_dut1 (
    .clk(clk), .rst_n(rst_n1), .sw_rst_req(sw_rst_req1), .dom_rdy(dom_rdy1),
    .dom_rst(dom_rst1), .seq_done(seq_done1), .seq_err(seq_err1), .err_dom(err_dom1)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s k=%0d obs=%0d exp=%0d", tag, cur_k, obs, exp);
  endtask

  // Schedule: domain i is released at rel[i]; it waits min(d,TMO-1)+1 cycles,
  // times out when d >= TMO, and the next release follows GAP edges later.
  task automatic model(input int dd[ND]);
    int t = HOLD;
    int ex = 0;
    err_e = NEVER * 10;
    err_i = 0;
    for (int i = 0; i < ND; i++) begin
      rel[i] = t;
      ex = t + 1 + ((dd[i] < TMO - 1) ? dd[i] : TMO - 1);
      if (dd[i] >= TMO && err_e == NEVER * 10) begin
        err_e = ex;
        err_i = i;
      end
      t = ex + GAP;
    end
    done_e = ex;
  endtask

  // Edge k counts rising edges since the sequence origin (reset or sw drop).
  task automatic run_body(input int dd[ND], input int stop_k, input bit toggle);
    logic [ND-1:0] exp_rst;
    int last_k;
    model(dd);
    last_k = (stop_k < 0) ? done_e + 6 : stop_k;
    for (int k = 1; k <= last_k; k++) begin
      @(posedge clk);
      @(negedge clk);
      cur_k = k;
      exp_rst = '0;
      for (int i = 0; i < ND; i++) if (k >= rel[i]) exp_rst[i] = 1'b1;
      chk("dom_rst", int'(dom_rst), int'(exp_rst));
      chk("seq_done", int'(seq_done), int'(k >= done_e));
      chk("seq_err", int'(seq_err), int'(k >= err_e));
      chk("err_dom", int'(err_dom), (k >= err_e) ? err_i : 0);
      for (int i = 0; i < ND; i++)
        dom_rdy[i] = (k >= rel[i]) && (k - rel[i] >= dd[i]);
      if (toggle && k >= done_e) dom_rdy = ND'($urandom);
    end
  endtask

  task automatic start_reset();
    rst_n = 1'b0;
    sw_rst_req = 1'b0;
    dom_rdy = '0;
    cur_k = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dom_rst", int'(dom_rst), 0);
    chk("rst_done", int'(seq_done), 0);
    chk("rst_err", int'(seq_err), 0);
    chk("rst_err_dom", int'(err_dom), 0);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dd[ND];
    int r;
    bit gap_seen;

    // nominal, ready immediately; then RDY toggling in RUN must be ignored
    start_reset();
    run_body('{0, 0, 0, 0}, -1, 1'b1);

    // async reset in RUN, then nominal timing must repeat
    #2 rst_n = 1'b0;
    #1;
    cur_k = -1;
    chk("async_dom_rst", int'(dom_rst), 0);
    chk("async_done", int'(seq_done), 0);
    chk("async_err", int'(seq_err), 0);
    dom_rdy = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    run_body('{0, 0, 0, 0}, -1, 1'b0);

    start_reset();
    run_body('{0, NEVER, 0, 0}, -1, 1'b0);
    start_reset();
    run_body('{0, NEVER, NEVER, 0}, -1, 1'b0);
    start_reset();
    run_body('{TMO - 1, TMO, 2, 0}, -1, 1'b0);

    // sw reset in the gap after domain 1, with an error already latched
    start_reset();
    dd = '{NEVER, 0, 0, 0};
    model(dd);
    run_body(dd, rel[1] + 2, 1'b0);
    sw_rst_req = 1'b1;
    dom_rdy = '0;
    for (int j = 1; j <= 5; j++) begin
      @(posedge clk);
      @(negedge clk);
      cur_k = -10 - j;
      chk("sw_dom_rst", int'(dom_rst), 0);
      chk("sw_done", int'(seq_done), 0);
      chk("sw_err", int'(seq_err), 0);
      chk("sw_err_dom", int'(err_dom), 0);
    end
    sw_rst_req = 1'b0;
    run_body('{1, 3, 0, 2}, -1, 1'b0);

    // randomized ready latencies, biased toward the timeout boundary
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < ND; i++) begin
        r = $urandom_range(0, 9);
        if (r < 6)      dd[i] = $urandom_range(0, 5);
        else if (r < 9) dd[i] = $urandom_range(TMO - 3, TMO + 2);
        else            dd[i] = NEVER;
      end
      start_reset();
      run_body(dd, -1, n[0]);
    end

    // single-domain instance: WAIT straight to RUN, GAP never visited
    gap_seen = 1'b0;
    @(posedge clk);
    #1 rst_n1 = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk);
      @(negedge clk);
      cur_k = k;
      if (u_dut1.state == ST_GAP) gap_seen = 1'b1;
      chk("d1_dom_rst", int'(dom_rst1), int'(k >= HOLD));
      chk("d1_done", int'(seq_done1), int'(k >= HOLD + 1));
      chk("d1_err", int'(seq_err1), 0);
    end
    chk("d1_gap_seen", int'(gap_seen), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rst_seq_ctrl.md
RST_SEQ_CTRL -- requirements
Module: rst_seq_ctrl

Interface
REQ-001 Parameter NUM_DOM, default 4: number of sequenced reset domains (1..8).
REQ-002 Parameter HOLD_CYC, default 8: cycles all domains are held in reset before the first release (>=1).
REQ-003 Parameter GAP_CYC, default 4: idle cycles between a domain becoming ready or timing out and the next release (>=1).
REQ-004 Parameter TMO_CYC, default 64: maximum cycles spent waiting for a domain's ready (>=1).
REQ-005 CLK  input  1  single clock; all logic on its rising edge.
REQ-006 RST  input  1  asynchronous, active-low reset, driven from an already-synchronized reset.
REQ-007 SW_RST_REQ  input  1  software reset request, level-sampled each cycle.
REQ-008 DOM_RDY  input  NUM_DOM  per-domain "out of reset and ready" flag.
REQ-009 DOM_RST  output  NUM_DOM  per-domain active-low reset: 0 = held, 1 = released.
REQ-010 SEQ_DONE  output  1  all domains released and sequence complete.
REQ-011 SEQ_ERR  output  1  sticky flag: at least one domain timed out.
REQ-012 ERR_DOM  output  clog2(NUM_DOM), min 1  index of the first domain that timed out.

Function
REQ-013 The FSM SHALL have exactly four states: HOLD, WAIT, GAP and RUN. It SHALL use an index register idx and one shared cycle counter cnt.
REQ-014 HOLD: all DOM_RST bits SHALL be 0, SEQ_DONE SHALL be 0 and cnt SHALL increment each cycle. When cnt==HOLD_CYC-1 the FSM SHALL go to WAIT, set DOM_RST[0]=1 on that edge and clear cnt.
REQ-015 WAIT: if DOM_RDY[idx]==1, the FSM SHALL go to RUN when idx==NUM_DOM-1 and to GAP otherwise.
REQ-016 WAIT timeout: if cnt==TMO_CYC-1 with DOM_RDY[idx]==0, the FSM SHALL take the same transition as REQ-015 and set SEQ_ERR=1. It SHALL load ERR_DOM=idx only if SEQ_ERR was 0 (the first failing domain is kept).
REQ-017 GAP: cnt SHALL count GAP_CYC cycles. On the cycle with cnt==GAP_CYC-1 the FSM SHALL increment idx, set DOM_RST[idx+1]=1, clear cnt and go to WAIT.
REQ-018 RUN: SEQ_DONE SHALL be 1, registered, from the first RUN cycle. Changes on DOM_RDY SHALL be ignored in RUN.
REQ-019 Released DOM_RST bits SHALL stay 1 until the next HOLD entry. Release order SHALL be strictly index 0 upward, one domain at a time.
REQ-020 If DOM_RDY[idx] is already 1 on the first WAIT cycle, the FSM SHALL spend exactly one cycle in WAIT.
REQ-021 SW_RST_REQ==1 in WAIT, GAP or RUN SHALL force HOLD on the next edge. On that edge: DOM_RST=0, SEQ_DONE=0, idx=0, cnt=0, SEQ_ERR=0, ERR_DOM=0.
REQ-022 SW_RST_REQ==1 in HOLD SHALL hold cnt at 0, extending the hold until the request drops.
REQ-023 SW_RST_REQ SHALL take priority over any same-cycle WAIT or GAP transition, ready or timeout.
REQ-024 When NUM_DOM==1, the FSM SHALL go from WAIT directly to RUN and never enter GAP.
REQ-025 cnt width SHALL be clog2(max(HOLD_CYC, GAP_CYC, TMO_CYC)). cnt SHALL never wrap in operation because every state exits at its terminal count.

Reset
REQ-026 RST==0 SHALL asynchronously force: state=HOLD, DOM_RST=0, SEQ_DONE=0, SEQ_ERR=0, ERR_DOM=0, idx=0, cnt=0.
REQ-027 RST asserted mid-sequence SHALL immediately return every domain to reset. After RST deasserts, the full sequence SHALL restart from REQ-014.
REQ-028 The first DOM_RST[0] rise SHALL occur on the HOLD_CYC-th rising edge after RST deassertion.

Structure
REQ-029 The state encodings and parameter defaults SHALL live in the shared package rst_seq_pkg, together with a clog2 helper function.
REQ-030 The cycle counter (clear, enable, terminal-count compare) SHALL be one sub-module, rst_seq_cnt. The FSM and output registers SHALL stay in rst_seq_ctrl.
REQ-031 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Verification
REQ-032 Nominal (defaults), DOM_RDY tied 1111, RST deasserted at edge 0 -> DOM_RST[0] rises at edge 8; then DOM_RST = 0011 at edge 13, 0111 at edge 18, 1111 at edge 23; SEQ_DONE=1 at edge 24; SEQ_ERR=0.
REQ-033 Timeout: DOM_RDY[1] held 0, all other bits 1 -> DOM_RST[1] is 1 for 64 WAIT cycles, then SEQ_ERR=1 and ERR_DOM=1; domains 2 and 3 are still released; SEQ_DONE=1.
REQ-034 Double timeout on domains 1 and 2 -> ERR_DOM stays 1.
REQ-035 SW reset in GAP after domain 1 is released -> next edge DOM_RST=0000, SEQ_ERR=0; SW_RST_REQ held 5 cycles -> DOM_RST[0] rises 8 edges after the request drops.
REQ-036 RST pulsed low in RUN -> all outputs 0 asynchronously, without waiting for an edge; the full REQ-032 timing repeats.
REQ-037 NUM_DOM=1, DOM_RDY=1 -> DOM_RST rises at edge 8 and SEQ_DONE=1 at edge 9; GAP is never visited (FSM coverage check).
